// File: rtl/fetch_pkg.sv
// Shared types for the fetch queue: the stored bundle layout and PC step.
// Field widths mirror the PD-stage defaults.
package fetch_pkg;

  localparam int FQ_XLEN        = 32;
  localparam int FQ_PHT_ADDRESS = 9;
  localparam int FQ_GHR_SIZE    = 9;
  localparam int FQ_RAS_ADDRESS = 3;
  localparam int INSTR_BYTES    = 4;

  typedef struct packed {
    logic [FQ_XLEN-1:0]        pc;
    logic [31:0]               instr1;
    logic [31:0]               instr2;
    logic                      pred_taken1;
    logic                      pred_taken2;
    logic                      btb_hit1;
    logic                      btb_hit2;
    logic [FQ_XLEN-1:0]        pred_target1;
    logic [FQ_XLEN-1:0]        pred_target2;
    logic [FQ_PHT_ADDRESS-1:0] pht_index1;
    logic [FQ_PHT_ADDRESS-1:0] pht_index2;
    logic [FQ_GHR_SIZE-1:0]    prev_ghr;
    logic [FQ_RAS_ADDRESS-1:0] sp_snap;
    logic [2*FQ_XLEN-1:0]      ras_snap;
    logic                      slot2_live;
  } fq_entry_t;

  function automatic logic [FQ_XLEN-1:0] slot2_pc(input logic [FQ_XLEN-1:0] pc);
    return pc + FQ_XLEN'(INSTR_BYTES);
  endfunction

  // A predicted-taken branch in slot 1 redirects fetch before slot 2 executes.
  function automatic logic kills_slot2(input logic taken, input logic hit);
    return taken && hit;
  endfunction

endpackage

// File: rtl/fq_ptr_ctrl.sv
// Fetch-queue pointer control: wrap-bit pointers, full/empty, occupancy, flush.
// Latency: pointer updates land on the next rising edge; flags are combinational from pointers.
// Backpressure: push is refused while full; pop is ignored while empty; flush beats both.
module fq_ptr_ctrl #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_req,
  input  logic                     pop_req,
  input  logic                     flush,
  output logic                     enq,
  output logic                     deq,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH)-1:0] wr_idx,
  output logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign enq    = push_req && !full && !flush;
  assign deq    = pop_req && !empty && !flush;
  assign wr_idx = wr_ptr[AW-1:0];
  assign rd_idx = rd_ptr[AW-1:0];
  assign count  = wr_ptr - rd_ptr;

  // Flush collapses the write pointer onto the read pointer; stale entries stay in the array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= rd_ptr;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// In-order buffer of two-instruction fetch bundles between PD and decode, show-ahead head.
// Latency: a bundle written at edge N is at the head after edge N; no empty bypass.
// Backpressure: pd_ready = !full, independent of dec_ready; mispredict flushes everything.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int PHT_ADDRESS = 9,
  parameter int GHR_SIZE    = 9,
  parameter int RAS_ADDRESS = 3,
  parameter int DEPTH       = 8
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic                     pd_valid,
  output logic                     pd_ready,
  input  logic [XLEN-1:0]          pd_pc,
  input  logic [31:0]              pd_instr1,
  input  logic [31:0]              pd_instr2,
  input  logic                     pd_pred_taken1,
  input  logic                     pd_pred_taken2,
  input  logic                     pd_btb_hit1,
  input  logic                     pd_btb_hit2,
  input  logic [XLEN-1:0]          pd_pred_target1,
  input  logic [XLEN-1:0]          pd_pred_target2,
  input  logic [PHT_ADDRESS-1:0]   pd_pht_index1,
  input  logic [PHT_ADDRESS-1:0]   pd_pht_index2,
  input  logic [GHR_SIZE-1:0]      pd_prev_ghr,
  input  logic [RAS_ADDRESS-1:0]   pd_sp_snap,
  input  logic [2*XLEN-1:0]        pd_ras_snap,
  input  logic                     mispredict,
  input  logic                     dec_ready,
  output logic                     fq_valid,
  output logic                     fq_slot2_valid,
  output logic [XLEN-1:0]          fq_pc1,
  output logic [XLEN-1:0]          fq_pc2,
  output logic [31:0]              fq_instr1,
  output logic [31:0]              fq_instr2,
  output logic                     fq_pred_taken1,
  output logic                     fq_pred_taken2,
  output logic                     fq_btb_hit1,
  output logic                     fq_btb_hit2,
  output logic [XLEN-1:0]          fq_pred_target1,
  output logic [XLEN-1:0]          fq_pred_target2,
  output logic [PHT_ADDRESS-1:0]   fq_pht_index1,
  output logic [PHT_ADDRESS-1:0]   fq_pht_index2,
  output logic [GHR_SIZE-1:0]      fq_prev_ghr,
  output logic [RAS_ADDRESS-1:0]   fq_sp_snap,
  output logic [2*XLEN-1:0]        fq_ras_snap,
  output logic [$clog2(DEPTH):0]   fq_count
);

  localparam int AW = $clog2(DEPTH);

  fq_entry_t mem [DEPTH];
  fq_entry_t wr_entry;
  fq_entry_t head;

  logic          enq;
  logic          deq;
  logic          full;
  logic          empty;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;

  fq_ptr_ctrl #(
    .DEPTH (DEPTH)
  ) u_ptr_ctrl (
    .clk      (CLK),
    .rst_n    (reset),
    .push_req (pd_valid),
    .pop_req  (dec_ready),
    .flush    (mispredict),
    .enq      (enq),
    .deq      (deq),
    .full     (full),
    .empty    (empty),
    .wr_idx   (wr_idx),
    .rd_idx   (rd_idx),
    .count    (fq_count)
  );

  assign pd_ready = !full;

  always_comb begin
    wr_entry              = '0;
    wr_entry.pc           = pd_pc;
    wr_entry.instr1       = pd_instr1;
    wr_entry.instr2       = pd_instr2;
    wr_entry.pred_taken1  = pd_pred_taken1;
    wr_entry.pred_taken2  = pd_pred_taken2;
    wr_entry.btb_hit1     = pd_btb_hit1;
    wr_entry.btb_hit2     = pd_btb_hit2;
    wr_entry.pred_target1 = pd_pred_target1;
    wr_entry.pred_target2 = pd_pred_target2;
    wr_entry.pht_index1   = pd_pht_index1;
    wr_entry.pht_index2   = pd_pht_index2;
    wr_entry.prev_ghr     = pd_prev_ghr;
    wr_entry.sp_snap      = pd_sp_snap;
    wr_entry.ras_snap     = pd_ras_snap;
    wr_entry.slot2_live   = !kills_slot2(pd_pred_taken1, pd_btb_hit1);
  end

  // Payload array carries no reset: content is only meaningful behind the pointers.
  always_ff @(posedge CLK) begin
    if (enq) mem[wr_idx] <= wr_entry;
  end

  assign head = mem[rd_idx];

  assign fq_valid        = !empty;
  assign fq_slot2_valid  = !empty && head.slot2_live;
  assign fq_pc1          = head.pc;
  assign fq_pc2          = slot2_pc(head.pc);
  assign fq_instr1       = head.instr1;
  assign fq_instr2       = head.instr2;
  assign fq_pred_taken1  = head.pred_taken1;
  assign fq_pred_taken2  = head.pred_taken2;
  assign fq_btb_hit1     = head.btb_hit1;
  assign fq_btb_hit2     = head.btb_hit2;
  assign fq_pred_target1 = head.pred_target1;
  assign fq_pred_target2 = head.pred_target2;
  assign fq_pht_index1   = head.pht_index1;
  assign fq_pht_index2   = head.pht_index2;
  assign fq_prev_ghr     = head.prev_ghr;
  assign fq_sp_snap      = head.sp_snap;
  assign fq_ras_snap     = head.ras_snap;

endmodule

// File: tb/tb_fetch_queue.sv
// Randomised and directed checks of fetch_queue against a queue-based reference model.
module tb_fetch_queue;

  localparam int DEPTH = 8;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr1;
    logic [31:0] instr2;
    logic        taken1;
    logic        taken2;
    logic        hit1;
    logic        hit2;
    logic [31:0] tgt1;
    logic [31:0] tgt2;
    logic [8:0]  pht1;
    logic [8:0]  pht2;
    logic [8:0]  ghr;
    logic [2:0]  sp;
    logic [63:0] ras;
  } bundle_t;

  logic    CLK;
  logic    reset;
  logic    pd_valid;
  logic    mispredict;
  logic    dec_ready;
  bundle_t in_b;

  logic        pd_ready;
  logic        fq_valid;
  logic        fq_slot2_valid;
  logic [31:0] fq_pc1, fq_pc2, fq_instr1, fq_instr2;
  logic        fq_pred_taken1, fq_pred_taken2, fq_btb_hit1, fq_btb_hit2;
  logic [31:0] fq_pred_target1, fq_pred_target2;
  logic [8:0]  fq_pht_index1, fq_pht_index2, fq_prev_ghr;
  logic [2:0]  fq_sp_snap;
  logic [63:0] fq_ras_snap;
  logic [3:0]  fq_count;

  bundle_t mq[$];
  int      n_cmp = 0;
  int      n_err = 0;

  fetch_queue dut (
    .CLK             (CLK),
    .reset           (reset),
    .pd_valid        (pd_valid),
    .pd_ready        (pd_ready),
    .pd_pc           (in_b.pc),
    .pd_instr1       (in_b.instr1),
    .pd_instr2       (in_b.instr2),
    .pd_pred_taken1  (in_b.taken1),
    .pd_pred_taken2  (in_b.taken2),
    .pd_btb_hit1     (in_b.hit1),
    .pd_btb_hit2     (in_b.hit2),
    .pd_pred_target1 (in_b.tgt1),
    .pd_pred_target2 (in_b.tgt2),
    .pd_pht_index1   (in_b.pht1),
    .pd_pht_index2   (in_b.pht2),
    .pd_prev_ghr     (in_b.ghr),
    .pd_sp_snap      (in_b.sp),
    .pd_ras_snap     (in_b.ras),
    .mispredict      (mispredict),
    .dec_ready       (dec_ready),
    .fq_valid        (fq_valid),
    .fq_slot2_valid  (fq_slot2_valid),
    .fq_pc1          (fq_pc1),
    .fq_pc2          (fq_pc2),
    .fq_instr1       (fq_instr1),
    .fq_instr2       (fq_instr2),
    .fq_pred_taken1  (fq_pred_taken1),
    .fq_pred_taken2  (fq_pred_taken2),
    .fq_btb_hit1     (fq_btb_hit1),
    .fq_btb_hit2     (fq_btb_hit2),
    .fq_pred_target1 (fq_pred_target1),
    .fq_pred_target2 (fq_pred_target2),
    .fq_pht_index1   (fq_pht_index1),
    .fq_pht_index2   (fq_pht_index2),
    .fq_prev_ghr     (fq_prev_ghr),
    .fq_sp_snap      (fq_sp_snap),
    .fq_ras_snap     (fq_ras_snap),
    .fq_count        (fq_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bundle_t rand_bundle();
    bundle_t b;
    b.pc     = {$urandom_range(0, 32'h3fff_ffff), 2'b00};
    b.instr1 = $urandom;
    b.instr2 = $urandom;
    b.taken1 = 1'($urandom_range(0, 1));
    b.taken2 = 1'($urandom_range(0, 1));
    b.hit1   = 1'($urandom_range(0, 1));
    b.hit2   = 1'($urandom_range(0, 1));
    b.tgt1   = $urandom;
    b.tgt2   = $urandom;
    b.pht1   = 9'($urandom);
    b.pht2   = 9'($urandom);
    b.ghr    = 9'($urandom);
    b.sp     = 3'($urandom);
    b.ras    = {$urandom, $urandom};
    return b;
  endfunction

  task automatic check_outputs(input string ph);
    bundle_t h;
    chk({ph, ".valid"}, 64'(fq_valid), 64'(mq.size() != 0));
    chk({ph, ".ready"}, 64'(pd_ready), 64'(mq.size() != DEPTH));
    chk({ph, ".count"}, 64'(fq_count), 64'(mq.size()));
    if (mq.size() == 0) begin
      chk({ph, ".s2v_empty"}, 64'(fq_slot2_valid), 64'(0));
    end else begin
      h = mq[0];
      chk({ph, ".pc1"},  64'(fq_pc1), 64'(h.pc));
      chk({ph, ".pc2"},  64'(fq_pc2), 64'(32'(h.pc + 32'd4)));
      chk({ph, ".s2v"},  64'(fq_slot2_valid), 64'(!(h.taken1 && h.hit1)));
      chk({ph, ".ins1"}, 64'(fq_instr1), 64'(h.instr1));
      chk({ph, ".ins2"}, 64'(fq_instr2), 64'(h.instr2));
      chk({ph, ".pred"}, 64'({fq_pred_taken1, fq_pred_taken2, fq_btb_hit1, fq_btb_hit2}),
          64'({h.taken1, h.taken2, h.hit1, h.hit2}));
      chk({ph, ".tgt1"}, 64'(fq_pred_target1), 64'(h.tgt1));
      chk({ph, ".tgt2"}, 64'(fq_pred_target2), 64'(h.tgt2));
      chk({ph, ".meta"}, 64'({fq_pht_index1, fq_pht_index2, fq_prev_ghr, fq_sp_snap}),
          64'({h.pht1, h.pht2, h.ghr, h.sp}));
      chk({ph, ".ras"},  fq_ras_snap, h.ras);
    end
  endtask

  // One clock with the currently driven inputs; model updated from queue-level rules.
  task automatic cycle(input string ph);
    bit      do_enq, do_deq;
    bundle_t b;
    b      = in_b;
    do_enq = pd_valid && (mq.size() < DEPTH) && !mispredict;
    do_deq = dec_ready && (mq.size() > 0) && !mispredict;
    @(posedge CLK);
    if (mispredict) mq.delete();
    else begin
      if (do_deq) void'(mq.pop_front());
      if (do_enq) mq.push_back(b);
    end
    #1;
    check_outputs(ph);
  endtask

  task automatic idle();
    pd_valid = 1'b0; dec_ready = 1'b0; mispredict = 1'b0;
  endtask

  task automatic push_pc(input logic [31:0] pc, input string ph);
    in_b = rand_bundle();
    in_b.pc = pc;
    pd_valid = 1'b1; dec_ready = 1'b0; mispredict = 1'b0;
    cycle(ph);
    idle();
  endtask

  task automatic drain(input string ph);
    pd_valid = 1'b0; dec_ready = 1'b1; mispredict = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) cycle(ph);
    idle();
  endtask

  initial begin
    idle();
    in_b  = '0;
    reset = 1'b0;

    // Reset
    repeat (2) @(posedge CLK);
    #1;
    chk("rst.valid", 64'(fq_valid), 64'(0));
    chk("rst.ready", 64'(pd_ready), 64'(1));
    chk("rst.count", 64'(fq_count), 64'(0));
    chk("rst.s2v",   64'(fq_slot2_valid), 64'(0));
    reset = 1'b1;

    // Single enqueue
    in_b = '0;
    in_b.pc = 32'h4; in_b.instr1 = 32'h13;
    pd_valid = 1'b1;
    cycle("single");
    idle();
    chk("single.valid", 64'(fq_valid), 64'(1));
    chk("single.pc1",   64'(fq_pc1), 64'(32'h4));
    chk("single.pc2",   64'(fq_pc2), 64'(32'h8));
    chk("single.s2v",   64'(fq_slot2_valid), 64'(1));
    chk("single.count", 64'(fq_count), 64'(1));

    // Predicted-taken slot 1 behind it, then pop the first bundle
    in_b = '0;
    in_b.pc = 32'h8; in_b.taken1 = 1'b1; in_b.hit1 = 1'b1; in_b.tgt1 = 32'hC;
    pd_valid = 1'b1;
    cycle("taken.enq");
    idle();
    dec_ready = 1'b1;
    cycle("taken.pop");
    idle();
    chk("taken.s2v", 64'(fq_slot2_valid), 64'(0));
    chk("taken.tgt", 64'(fq_pred_target1), 64'(32'hC));
    drain("taken.drain");

    // Fill / overflow / drain, three rounds to exercise pointer wrap
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < DEPTH; i++) push_pc(32'(i * 8), "fill");
      chk("fill.ready", 64'(pd_ready), 64'(0));
      chk("fill.count", 64'(fq_count), 64'(8));
      push_pc(32'h40, "ovf");
      chk("ovf.count", 64'(fq_count), 64'(8));
      dec_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        chk("drain.order", 64'(fq_pc1), 64'(32'(i * 8)));
        cycle("drain");
      end
      idle();
      chk("drain.empty", 64'(fq_valid), 64'(0));
    end

    // Concurrent enqueue/dequeue at count 3
    for (int i = 0; i < 3; i++) push_pc(32'h100 + 32'(i * 8), "conc.pre");
    pd_valid = 1'b1; dec_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_b = rand_bundle();
      cycle("conc");
      chk("conc.count", 64'(fq_count), 64'(3));
    end
    idle();
    drain("conc.drain");

    // Flush at count 5 with an incoming bundle
    for (int i = 0; i < 5; i++) push_pc(32'h200 + 32'(i * 8), "flush.pre");
    in_b = rand_bundle();
    pd_valid = 1'b1; mispredict = 1'b1;
    cycle("flush");
    idle();
    chk("flush.count", 64'(fq_count), 64'(0));
    chk("flush.valid", 64'(fq_valid), 64'(0));
    push_pc(32'h0040_1000, "redirect");
    chk("redirect.pc1", 64'(fq_pc1), 64'(32'h0040_1000));
    drain("redirect.drain");

    // Asynchronous reset mid-stream at count 3
    for (int i = 0; i < 3; i++) push_pc(32'h300 + 32'(i * 8), "arst.pre");
    chk("arst.pre_count", 64'(fq_count), 64'(3));
    reset = 1'b0;
    #2;
    chk("arst.count", 64'(fq_count), 64'(0));
    chk("arst.valid", 64'(fq_valid), 64'(0));
    chk("arst.ready", 64'(pd_ready), 64'(1));
    mq.delete();
    @(posedge CLK);
    #1;
    reset = 1'b1;

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      in_b       = rand_bundle();
      pd_valid   = ($urandom_range(0, 3) != 0);
      dec_ready  = ($urandom_range(0, 2) == 0);
      mispredict = ($urandom_range(0, 19) == 0);
      cycle("rand");
    end
    idle();
    drain("final.drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
